uart_rx_interface: RTL and testbench
====================================

Name: uart_rx_interface

Overview:
- Wishbone-style register slave wrapping a UART receiver: the receive-direction counterpart of the existing uart_interface transmitter.
- Samples the asynchronous serial line `uart_rx`, deframes 8N1 characters at a programmable baud divisor, and holds each byte in a data register. The CPU/bus master polls or takes an interrupt.
- Sits on the same bus segment as uart_interface. It uses its own address decode.

Parameters:
- DIV_W, 16, width of the baud divisor register (clocks per bit).
- DIV_RST, 16'd868, divisor value loaded at reset.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- addr_i  in  32  register address; only addr_i[3:0] decoded, upper bits must be 0.
- dat_i  in  32  write data.
- dat_o  out  32  read data, valid while ack_o=1.
- we_i  in  1  1=write, 0=read.
- sel_i  in  8  byte selects; accepted, ignored (full-word access).
- cyc_i  in  1  accepted, not required; access is qualified by stb_i alone.
- stb_i  in  1  access strobe.
- lock_i  in  1  accepted, ignored.
- err_o  out  1  error acknowledge (unmapped address).
- rty_o  out  1  tied 0.
- ack_o  out  1  normal acknowledge.
- tagn_i  in  1  tag in.
- tagn_o  out  1  tagn_i registered, aligned with ack_o/err_o.
- uart_rx  in  1  asynchronous serial input, idle high.
- irq_o  out  1  interrupt: (valid & ie) | ((fe|ovr) & ie).

Behaviour:
- Reset (synchronous, rst_i=1 at clk edge) sets:
  - dat_o=0, ack_o=0, err_o=0, tagn_o=0, irq_o=0.
  - ctrl=0, div=DIV_RST, data=0, status flags=0.
  - FSM=IDLE, synchronizer flops=1.
  - Reset mid-frame abandons the frame; no flag is set.
- Register map (word index on addr_i):
  - 0x0 CTRL RW: [0] en, [1] ie, [2] soft_rst (write-1 self-clearing; returns FSM to IDLE next cycle, does not touch div/ctrl).
  - 0x1 DIV RW: [DIV_W-1:0] clocks per bit. Values <4 are treated as 4.
  - 0x2 STATUS: [0] valid, [1] fe (framing error), [2] ovr (overrun), [3] busy (FSM≠IDLE).
    - Read: returns the flags.
    - Any write: clears fe and ovr; valid is unaffected.
  - 0x3 DATA RO: [7:0] last received byte. A read clears valid in the same cycle ack_o is issued. Writes are acked and have no effect.
  - Any other address: err_o instead of ack_o, dat_o=0, no side effects.
- Bus handshake:
  - stb_i=1 sampled at edge N gives ack_o (or err_o) =1 for exactly one cycle at edge N+1, with dat_o and tagn_o valid in that cycle.
  - stb_i held high for multiple cycles gives one ack per sampled edge. Side effects occur once per ack.
  - Write and read side effects take place at edge N+1.
- Input path: 2-flop synchronizer on uart_rx (2 cycles latency). Falling-edge detection uses the synchronized value and its previous value.
- FSM:
  - IDLE: when en=1 and a falling edge is seen, load cnt=div>>1 and go to START.
  - START: count down to 0, then sample.
    - Low: load cnt=div-1, bit=0, go to DATA.
    - High: false start, back to IDLE, no flags.
  - DATA: at cnt=0 sample into shift[bit] (LSB first) and reload cnt=div-1. After bit 7 go to STOP.
  - STOP: at cnt=0 sample.
    - High: if valid=0, load data=shift and set valid. If valid=1, keep old data and set ovr.
    - Low: set fe; data and valid are unchanged.
    - Either way return to IDLE (a new start is detectable on the next cycle).
- Simultaneous events:
  - A DATA read clearing valid in the same cycle as a STOP commit: the new byte wins (valid=1, data=new), no ovr.
  - A STATUS write in the same cycle as an fe/ovr set: the set wins.
- en=0 takes effect only in IDLE. A frame in progress completes.
- A DIV write during a frame takes effect at the next counter reload.
- irq_o is registered and updates one cycle after the flag changes.

Test Plan:
- Set DIV=16, CTRL=0x3, drive 0x9A 8N1 at 16 clk/bit → STATUS reads 0x1, DATA reads 0x9A, irq_o=1 and drops after the DATA read, STATUS then reads 0x0.
- Low glitch of 4 clocks on uart_rx with DIV=16 → FSM returns to IDLE, STATUS=0x0, no irq.
- Frame 0x55 with stop bit driven low → STATUS=0x2, DATA unchanged. A write to STATUS gives STATUS=0x0.
- Receive 0x12 then 0x34 without reading DATA → DATA=0x12, STATUS=0x5.
- Assert rst_i during data bit 3 of a frame, release, then send 0xA5 → no flags before the new frame; DATA=0xA5 after it; DIV reads DIV_RST after reset.
- Bus checks:
  - Read at addr 0x7 → err_o pulse 1 cycle, ack_o=0.
  - Write DIV=32766 then read it back → ack one cycle after stb_i, dat_o=32766 (DIV_W=16).
  - tagn_i=1 is mirrored on tagn_o with the ack.

Source files
------------

// File: rtl/uart_rx_interface.sv
// uart_rx_interface
//   Bus register slave around an 8N1 UART receiver. The serial line is
//   synchronised, deframed at a programmable clocks-per-bit divisor, and
//   each received byte is held in a data register. Status flags report
//   valid data, framing errors and overruns. An optional interrupt is raised
//   while any flag is set.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   addr_i            register address, word index on addr_i[3:0]
//   dat_i / dat_o     write data / read data (dat_o valid with ack_o)
//   we_i, stb_i       write enable, access strobe (one ack per sampled strobe)
//   sel_i, cyc_i,     accepted and ignored
//   lock_i
//   ack_o, err_o      normal acknowledge / unmapped-address acknowledge
//   rty_o             always 0
//   tagn_i / tagn_o   tag, registered so it lines up with ack_o/err_o
//   uart_rx           asynchronous serial input, idle high
//   irq_o             registered interrupt: ie & (valid | fe | ovr)
//
// Register map (addr_i[3:0])
//   0x0 CTRL   [0] en, [1] ie, [2] soft_rst (write-1, self-clearing)
//   0x1 DIV    clocks per bit, values below 4 behave as 4
//   0x2 STATUS [0] valid, [1] fe, [2] ovr, [3] busy; any write clears fe/ovr
//   0x3 DATA   [7:0] last byte; a read clears valid
module uart_rx_interface #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(868)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [7:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        lock_i,
  output logic        err_o,
  output logic        rty_o,
  output logic        ack_o,
  input  logic        tagn_i,
  output logic        tagn_o,
  input  logic        uart_rx,
  output logic        irq_o
);

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_DIV    = 4'h1;
  localparam logic [3:0] ADDR_STATUS = 4'h2;
  localparam logic [3:0] ADDR_DATA   = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Bus-side registers
  logic [31:0]      dat_reg;
  logic             ack_reg;
  logic             err_reg;
  logic             tagn_reg;
  logic             irq_reg;
  logic             en_reg;
  logic             ie_reg;
  logic             soft_rst_reg;
  logic [DIV_W-1:0] div_reg;

  // Receiver registers
  logic [1:0]       sync_reg;
  logic             rx_prev_reg;
  state_t           state_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;
  logic             fe_reg;
  logic             ovr_reg;

  logic             rx_sync;
  logic             rx_fall;
  logic             busy;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_half;
  logic [DIV_W-1:0] div_reload;
  logic [3:0]       reg_addr;
  logic             data_rd;
  logic             status_wr;

  // Inputs that the register interface accepts but has no use for.
  logic unused_inputs;
  assign unused_inputs = ^{sel_i, cyc_i, lock_i, addr_i[31:4], dat_i};

  assign rx_sync  = sync_reg[1];
  assign rx_fall  = rx_prev_reg & ~rx_sync;
  assign busy     = (state_reg != ST_IDLE);
  assign reg_addr = addr_i[3:0];

  // Very small divisors cannot place a sample inside the bit, so clamp.
  assign div_eff    = (div_reg < DIV_W'(4)) ? DIV_W'(4) : div_reg;
  assign div_half   = div_eff >> 1;
  assign div_reload = div_eff - DIV_W'(1);

  // Bus accesses with side effects on the receiver's flags.
  assign data_rd   = stb_i & ~we_i & (reg_addr == ADDR_DATA);
  assign status_wr = stb_i &  we_i & (reg_addr == ADDR_STATUS);

  assign dat_o  = dat_reg;
  assign ack_o  = ack_reg;
  assign err_o  = err_reg;
  assign rty_o  = 1'b0;
  assign tagn_o = tagn_reg;
  assign irq_o  = irq_reg;

  // Two-flop synchroniser plus the previous synchronised value for
  // falling-edge detection. All reset high to match the idle line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], uart_rx};
      rx_prev_reg <= rx_sync;
    end
  end

  // Register interface: one registered ack/err per sampled strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_reg      <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      tagn_reg     <= 1'b0;
      irq_reg      <= 1'b0;
      en_reg       <= 1'b0;
      ie_reg       <= 1'b0;
      soft_rst_reg <= 1'b0;
      div_reg      <= DIV_RST;
    end else begin
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      dat_reg      <= '0;
      soft_rst_reg <= 1'b0;
      tagn_reg     <= tagn_i;
      irq_reg      <= ie_reg & (valid_reg | fe_reg | ovr_reg);
      if (stb_i) begin
        case (reg_addr)
          ADDR_CTRL: begin
            ack_reg <= 1'b1;
            if (we_i) begin
              en_reg       <= dat_i[0];
              ie_reg       <= dat_i[1];
              soft_rst_reg <= dat_i[2];
            end else begin
              dat_reg <= {30'd0, ie_reg, en_reg};
            end
          end
          ADDR_DIV: begin
            ack_reg <= 1'b1;
            if (we_i) begin
              div_reg <= dat_i[DIV_W-1:0];
            end else begin
              dat_reg <= 32'(div_reg);
            end
          end
          ADDR_STATUS: begin
            ack_reg <= 1'b1;
            if (!we_i) begin
              dat_reg <= {28'd0, busy, ovr_reg, fe_reg, valid_reg};
            end
          end
          ADDR_DATA: begin
            ack_reg <= 1'b1;
            if (!we_i) begin
              dat_reg <= {24'd0, data_reg};
            end
          end
          default: begin
            err_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  // Receiver FSM and status flags. Bus-driven clears are written first so
  // that a flag set by the FSM in the same cycle overrides them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      fe_reg    <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      if (data_rd) begin
        valid_reg <= 1'b0;
      end
      if (status_wr) begin
        fe_reg  <= 1'b0;
        ovr_reg <= 1'b0;
      end

      if (soft_rst_reg) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (en_reg && rx_fall) begin
              cnt_reg   <= div_half;
              state_reg <= ST_START;
            end
          end
          ST_START: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end else if (!rx_sync) begin
              cnt_reg   <= div_reload;
              bit_reg   <= 3'd0;
              state_reg <= ST_DATA;
            end else begin
              // Line was high again at mid-bit: a glitch, not a start bit.
              state_reg <= ST_IDLE;
            end
          end
          ST_DATA: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end else begin
              shift_reg[bit_reg] <= rx_sync;
              cnt_reg            <= div_reload;
              if (bit_reg == 3'd7) begin
                state_reg <= ST_STOP;
              end else begin
                bit_reg <= bit_reg + 3'd1;
              end
            end
          end
          ST_STOP: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end else begin
              if (rx_sync) begin
                // A DATA read in this same cycle frees the holding register,
                // so the new byte is accepted rather than flagged as overrun.
                if (!valid_reg || data_rd) begin
                  data_reg  <= shift_reg;
                  valid_reg <= 1'b1;
                end else begin
                  ovr_reg <= 1'b1;
                end
              end else begin
                fe_reg <= 1'b1;
              end
              state_reg <= ST_IDLE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_interface.sv
// Self-checking bench for uart_rx_interface: directed scenarios plus a
// randomized stream of frames, all checked against a register-level model
// of the receiver's flags and data.
module tb_uart_rx_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [31:0] dat_o;
  logic        we;
  logic        stb;
  logic        err_o;
  logic        rty_o;
  logic        ack_o;
  logic        tagn_in;
  logic        tagn_o;
  logic        uart_rx;
  logic        irq_o;

  always #5 clk = ~clk;

  uart_rx_interface #(
    .DIV_W  (16),
    .DIV_RST(16'd868)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .addr_i (addr),
    .dat_i  (dat_w),
    .dat_o  (dat_o),
    .we_i   (we),
    .sel_i  (8'hFF),
    .cyc_i  (stb),
    .stb_i  (stb),
    .lock_i (1'b0),
    .err_o  (err_o),
    .rty_o  (rty_o),
    .ack_o  (ack_o),
    .tagn_i (tagn_in),
    .tagn_o (tagn_o),
    .uart_rx(uart_rx),
    .irq_o  (irq_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the programmer-visible state.
  logic       m_valid, m_fe, m_ovr, m_en, m_ie;
  logic [7:0] m_data;
  int         m_div;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ovr   = 1'b0;
    m_en    = 1'b0;
    m_ie    = 1'b0;
    m_data  = 8'h00;
    m_div   = 868;
  endfunction

  // A completed frame: good stop bit delivers or overruns, bad stop bit
  // flags a framing error. Nothing happens while the receiver is disabled.
  function automatic void model_frame(input logic [7:0] b, input logic good);
    if (m_en) begin
      if (good) begin
        if (m_valid) m_ovr = 1'b1;
        else begin
          m_data  = b;
          m_valid = 1'b1;
        end
      end else begin
        m_fe = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_status(input logic busy);
    return {28'd0, busy, m_ovr, m_fe, m_valid};
  endfunction

  function automatic logic [31:0] exp_irq();
    return {31'd0, m_ie & (m_valid | m_fe | m_ovr)};
  endfunction

  function automatic int eff_div();
    return (m_div < 4) ? 4 : m_div;
  endfunction

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic tg,
                     output logic [31:0] rdat, output logic ak, output logic er, output logic to);
    @(posedge clk); #1;
    addr = a; we = w; dat_w = wd; tagn_in = tg; stb = 1'b1;
    @(posedge clk); #1;
    rdat = dat_o; ak = ack_o; er = err_o; to = tagn_o;
    stb = 1'b0; we = 1'b0; tagn_in = 1'b0; dat_w = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic ak, er, to;
    bus(a, 1'b1, d, 1'b0, r, ak, er, to);
    check_val($sformatf("wr_ack_%0h", a), {31'd0, ak}, 32'd1);
    if (a == 0) begin m_en = d[0]; m_ie = d[1]; end
    if (a == 1) m_div = int'(d[15:0]);
    if (a == 2) begin m_fe = 1'b0; m_ovr = 1'b0; end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic ak, er, to;
    bus(a, 1'b0, '0, 1'b0, r, ak, er, to);
    check_val({tag, "_ack"}, {31'd0, ak}, 32'd1);
    check_val(tag, r, exp);
    if (a == 3) m_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      uart_rx = bits[k];
      repeat (d) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (d) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic ak, er, to;
    int acks;

    rst = 1'b1; addr = '0; dat_w = '0; we = 1'b0; stb = 1'b0; tagn_in = 1'b0; uart_rx = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_val("rst_ack", {31'd0, ack_o}, 32'd0);
    check_val("rst_err", {31'd0, err_o}, 32'd0);
    check_val("rst_dat", dat_o, 32'd0);
    check_val("rst_irq", {31'd0, irq_o}, 32'd0);
    check_val("rst_tagn", {31'd0, tagn_o}, 32'd0);
    check_val("rst_rty", {31'd0, rty_o}, 32'd0);
    rd_chk("rst_div", 1, 32'd868);
    rd_chk("rst_ctrl", 0, 32'd0);
    rd_chk("rst_status", 2, exp_status(1'b0));

    // Unmapped address: err instead of ack, no data
    bus(32'h7, 1'b0, '0, 1'b0, r, ak, er, to);
    check_val("unmapped_err", {31'd0, er}, 32'd1);
    check_val("unmapped_ack", {31'd0, ak}, 32'd0);
    check_val("unmapped_dat", r, 32'd0);
    @(posedge clk); #1;
    check_val("unmapped_err_pulse", {31'd0, err_o}, 32'd0);

    // DIV write timing, single ack pulse, tag mirroring
    @(posedge clk); #1;
    addr = 32'h1; we = 1'b1; dat_w = 32'd32766; tagn_in = 1'b1; stb = 1'b1;
    check_val("div_ack_before", {31'd0, ack_o}, 32'd0);
    @(posedge clk); #1;
    check_val("div_ack", {31'd0, ack_o}, 32'd1);
    check_val("div_tagn", {31'd0, tagn_o}, 32'd1);
    stb = 1'b0; we = 1'b0; tagn_in = 1'b0;
    @(posedge clk); #1;
    check_val("div_ack_pulse", {31'd0, ack_o}, 32'd0);
    m_div = 32766;
    rd_chk("div_32766", 1, 32'd32766);

    // Strobe held for three edges gives three acks
    acks = 0;
    @(posedge clk); #1;
    addr = 32'h1; we = 1'b0; stb = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack_o) acks++;
    end
    stb = 1'b0;
    @(posedge clk); #1;
    if (ack_o) acks++;
    check_val("held_acks", acks, 32'd3);

    // Basic reception of 0x9A with interrupt
    wr(1, 16);
    wr(0, 3);
    send_frame(8'h9A, 1'b1, 16);
    model_frame(8'h9A, 1'b1);
    $display("frame byte=9a stop=1 div=16");
    check_val("9a_irq", {31'd0, irq_o}, exp_irq());
    rd_chk("9a_status", 2, exp_status(1'b0));
    rd_chk("9a_data", 3, {24'd0, m_data});
    @(posedge clk); #1;
    check_val("9a_irq_drop", {31'd0, irq_o}, exp_irq());
    rd_chk("9a_status_after", 2, exp_status(1'b0));

    // Short low glitch: busy while checking, then back to idle with no flags
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    rd_chk("glitch_busy", 2, exp_status(1'b1));
    repeat (40) @(posedge clk);
    #1;
    rd_chk("glitch_status", 2, exp_status(1'b0));
    check_val("glitch_irq", {31'd0, irq_o}, exp_irq());

    // Framing error on 0x55
    send_frame(8'h55, 1'b0, 16);
    model_frame(8'h55, 1'b0);
    $display("frame byte=55 stop=0 div=16");
    check_val("fe_irq", {31'd0, irq_o}, exp_irq());
    rd_chk("fe_status", 2, exp_status(1'b0));
    rd_chk("fe_data", 3, {24'd0, m_data});
    wr(2, 0);
    rd_chk("fe_cleared", 2, exp_status(1'b0));

    // Overrun: 0x12 then 0x34 without reading
    send_frame(8'h12, 1'b1, 16);
    model_frame(8'h12, 1'b1);
    $display("frame byte=12 stop=1 div=16");
    send_frame(8'h34, 1'b1, 16);
    model_frame(8'h34, 1'b1);
    $display("frame byte=34 stop=1 div=16");
    rd_chk("ovr_status", 2, exp_status(1'b0));
    rd_chk("ovr_data", 3, {24'd0, m_data});
    wr(2, 0);

    // Receiver disabled: frame ignored
    wr(0, 2);
    send_frame(8'h77, 1'b1, 16);
    model_frame(8'h77, 1'b1);
    $display("frame byte=77 stop=1 div=16 en=0");
    rd_chk("dis_status", 2, exp_status(1'b0));
    wr(0, 3);

    // Divisor below 4 behaves as 4
    wr(1, 2);
    rd_chk("div2_rb", 1, 32'd2);
    send_frame(8'h3C, 1'b1, eff_div());
    model_frame(8'h3C, 1'b1);
    $display("frame byte=3c stop=1 div=2");
    rd_chk("div2_status", 2, exp_status(1'b0));
    rd_chk("div2_data", 3, {24'd0, m_data});

    // Soft reset mid-frame returns to idle, ctrl bits kept, soft bit reads 0
    wr(1, 16);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (8) @(posedge clk);
    wr(0, 7);
    rd_chk("soft_ctrl", 0, 32'd3);
    rd_chk("soft_busy", 2, exp_status(1'b0));
    repeat (250) @(posedge clk);
    #1;
    rd_chk("soft_status", 2, exp_status(1'b0));

    // Randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      logic [7:0]  b;
      logic        good;
      int          act;
      logic [31:0] nd;
      if ($urandom_range(0, 3) == 0) begin
        nd = 32'(8 + 4 * $urandom_range(0, 3));
        wr(1, nd);
        rd_chk("rnd_div", 1, nd);
      end
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      send_frame(b, good, eff_div());
      model_frame(b, good);
      $display("frame byte=%02h stop=%0d div=%0d", b, good, eff_div());
      check_val("rnd_irq", {31'd0, irq_o}, exp_irq());
      rd_chk("rnd_status", 2, exp_status(1'b0));
      act = int'($urandom_range(0, 2));
      if (act == 0) rd_chk("rnd_data", 3, {24'd0, m_data});
      if (act == 1) wr(2, 0);
    end

    // Reset during data bit 3, then a clean frame
    wr(1, 16);
    wr(0, 3);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 uart_rx = k[0] ? 1'b0 : 1'b1;
      repeat (16) @(posedge clk);
    end
    #1 uart_rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; uart_rx = 1'b1;
    model_reset();
    repeat (300) @(posedge clk);
    #1;
    rd_chk("mid_rst_status", 2, exp_status(1'b0));
    check_val("mid_rst_irq", {31'd0, irq_o}, exp_irq());
    rd_chk("mid_rst_div", 1, 32'd868);
    rd_chk("mid_rst_ctrl", 0, 32'd0);
    wr(1, 16);
    wr(0, 3);
    send_frame(8'hA5, 1'b1, 16);
    model_frame(8'hA5, 1'b1);
    $display("frame byte=a5 stop=1 div=16");
    rd_chk("a5_status", 2, exp_status(1'b0));
    rd_chk("a5_data", 3, {24'd0, m_data});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
